// File: rtl/sprite_line_engine.sv
// sprite_line_engine
//   Per-scanline sprite renderer. During horizontal blanking it walks the
//   sprite attribute table, picks up to MAX_PER_LINE sprites that hit the
//   next line and fetches their pattern rows into shadow slots. At the end of
//   blanking the shadow slots become the active set. During active video it
//   emits a prioritised {palette, pixel} index per column.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   chipselect      bus select
//   write           bus write strobe
//   address[15:0]   [9:8]=00 attribute table (idx [7:0]), 01 pattern RAM (word [7:0])
//   writedata[31:0] attribute word or pattern row
//   hcount[10:0]    horizontal counter 0..1599, column = hcount[10:1]
//   vcount[9:0]     vertical counter 0..524
//   pix_index       {palette, pixel} of the winning sprite, 0 when none
//   pix_opaque      1 when a sprite pixel is visible
//   line_overflow   1 for the whole line when more than MAX_PER_LINE sprites hit it
//   collision       sticky, two opaque sprite pixels coincided this frame
module sprite_line_engine #(
  parameter int NUM_SPRITES  = 16,
  parameter int MAX_PER_LINE = 8,
  parameter int SPRITE_W     = 16,
  parameter int SPRITE_H     = 16,
  parameter int BPP          = 2,
  parameter int NUM_PATTERNS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipselect,
  input  logic             write,
  input  logic [15:0]      address,
  input  logic [31:0]      writedata,
  input  logic [10:0]      hcount,
  input  logic [9:0]       vcount,
  output logic [BPP+3:0]   pix_index,
  output logic             pix_opaque,
  output logic             line_overflow,
  output logic             collision
);

  localparam int RW     = SPRITE_W * BPP;
  localparam int HW     = $clog2(SPRITE_H);
  localparam int CW     = $clog2(SPRITE_W);
  localparam int PDEPTH = NUM_PATTERNS * SPRITE_H;
  localparam int PAW    = $clog2(PDEPTH);
  localparam int IW     = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int NW     = $clog2(MAX_PER_LINE + 1);
  localparam int SW     = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ATTR, S_CHK, S_LOAD, S_NEXT, S_DONE
  } state_t;

  // ---------------- bus write capture and tables ----------------
  logic        wr_en_reg;
  logic [9:0]  wr_addr_reg;
  logic [31:0] wr_data_reg;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^address[15:10];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg   <= chipselect && write;
      wr_addr_reg <= address[9:0];
      wr_data_reg <= writedata;
    end
  end

  logic [31:0]   attr_mem [NUM_SPRITES];
  logic [RW-1:0] pat_mem  [PDEPTH];
  logic [31:0]   attr_rd_reg;
  logic [RW-1:0] pat_rd_reg;
  logic          attr_rd;
  logic          pat_rd;
  logic [PAW-1:0] pat_addr;
  state_t        state_reg, state_next;
  logic [IW-1:0] i_reg, i_next;
  logic [NW-1:0] n_reg, n_next;

  always_ff @(posedge clk) begin
    if (wr_en_reg && wr_addr_reg[9:8] == 2'b00 && 32'(wr_addr_reg[7:0]) < NUM_SPRITES)
      attr_mem[IW'(wr_addr_reg[7:0])] <= wr_data_reg;
    if (wr_en_reg && wr_addr_reg[9:8] == 2'b01 && 32'(wr_addr_reg[7:0]) < PDEPTH)
      pat_mem[PAW'(wr_addr_reg[7:0])] <= RW'(wr_data_reg);
    if (attr_rd)
      attr_rd_reg <= attr_mem[i_reg];
    if (pat_rd)
      pat_rd_reg <= pat_mem[pat_addr];
  end

  // ---------------- attribute decode for the entry under check ----------------
  logic [8:0] attr_y;
  logic [9:0] attr_x;
  logic [6:0] attr_pat;
  logic [3:0] attr_pal;
  logic       attr_flip;
  logic       attr_en;
  logic [8:0] target_line;
  logic [8:0] row_diff;
  logic       hit;

  assign attr_y    = attr_rd_reg[8:0];
  assign attr_x    = attr_rd_reg[18:9];
  assign attr_pat  = attr_rd_reg[25:19];
  assign attr_pal  = attr_rd_reg[29:26];
  assign attr_flip = attr_rd_reg[30];
  assign attr_en   = attr_rd_reg[31];

  // The y field is 9 bits wide, so the vertical distance is taken modulo 512.
  // A y near the top of its range (e.g. 508) therefore acts as a small
  // negative offset and lets a sprite enter from above line 0.
  assign target_line = (vcount == 10'd524) ? 9'd0 : vcount[8:0] + 9'd1;
  assign row_diff    = target_line - attr_y;
  assign hit         = attr_en && (row_diff < 9'(SPRITE_H));
  assign pat_addr    = PAW'({attr_pat, row_diff[HW-1:0]});

  // ---------------- scan FSM ----------------
  logic clr_shadow, load_slot, set_ovf, copy_active;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      i_reg     <= '0;
      n_reg     <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      n_reg     <= n_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    i_next      = i_reg;
    n_next      = n_reg;
    clr_shadow  = 1'b0;
    load_slot   = 1'b0;
    set_ovf     = 1'b0;
    copy_active = 1'b0;
    attr_rd     = 1'b0;
    pat_rd      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (hcount == 11'd1280) begin
          clr_shadow = 1'b1;
          i_next     = '0;
          n_next     = '0;
          state_next = S_RD_ATTR;
        end
      end
      S_RD_ATTR: begin
        attr_rd    = 1'b1;
        state_next = S_CHK;
      end
      S_CHK: begin
        if (hit && n_reg < NW'(MAX_PER_LINE)) begin
          pat_rd     = 1'b1;
          state_next = S_LOAD;
        end else begin
          set_ovf    = hit;
          state_next = S_NEXT;
        end
      end
      S_LOAD: begin
        load_slot  = 1'b1;
        n_next     = n_reg + 1'b1;
        state_next = S_NEXT;
      end
      S_NEXT: begin
        if (i_reg == IW'(NUM_SPRITES - 1)) begin
          state_next = S_DONE;
        end else begin
          i_next     = i_reg + 1'b1;
          state_next = S_RD_ATTR;
        end
      end
      S_DONE: begin
        // The active set only changes at the last blanking cycle, so it is
        // stable for the whole visible part of the following line.
        if (hcount == 11'd1599) begin
          copy_active = 1'b1;
          state_next  = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- shadow and active slots ----------------
  logic [MAX_PER_LINE-1:0] shadow_valid, active_valid;
  logic                    shadow_ovf;
  logic [9:0]    shadow_x    [MAX_PER_LINE];
  logic [3:0]    shadow_pal  [MAX_PER_LINE];
  logic          shadow_flip [MAX_PER_LINE];
  logic [RW-1:0] shadow_row  [MAX_PER_LINE];
  logic [9:0]    active_x    [MAX_PER_LINE];
  logic [3:0]    active_pal  [MAX_PER_LINE];
  logic          active_flip [MAX_PER_LINE];
  logic [RW-1:0] active_row  [MAX_PER_LINE];

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_valid <= '0;
      active_valid <= '0;
      shadow_ovf   <= 1'b0;
    end else begin
      if (clr_shadow) begin
        shadow_valid <= '0;
        shadow_ovf   <= 1'b0;
      end
      if (set_ovf)
        shadow_ovf <= 1'b1;
      if (load_slot)
        shadow_valid[n_reg[SW-1:0]] <= 1'b1;
      if (copy_active)
        active_valid <= shadow_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (load_slot) begin
      shadow_x[n_reg[SW-1:0]]    <= attr_x;
      shadow_pal[n_reg[SW-1:0]]  <= attr_pal;
      shadow_flip[n_reg[SW-1:0]] <= attr_flip;
      shadow_row[n_reg[SW-1:0]]  <= pat_rd_reg;
    end
    if (copy_active) begin
      for (int k = 0; k < MAX_PER_LINE; k++) begin
        active_x[k]    <= shadow_x[k];
        active_pal[k]  <= shadow_pal[k];
        active_flip[k] <= shadow_flip[k];
        active_row[k]  <= shadow_row[k];
      end
    end
  end

  // ---------------- per-slot pixel evaluation ----------------
  logic [10:0]             col11;
  logic [BPP-1:0]          slot_px [MAX_PER_LINE];
  logic [MAX_PER_LINE-1:0] slot_hit;

  assign col11 = {1'b0, hcount[10:1]};

  generate
    for (genvar gi = 0; gi < MAX_PER_LINE; gi++) begin : g_slot
      logic [10:0]   lo;
      logic [10:0]   hi;
      logic [CW-1:0] c;
      logic [CW-1:0] ci;

      assign lo = {1'b0, active_x[gi]};
      assign hi = lo + 11'(SPRITE_W);
      assign c  = CW'(col11 - lo);
      assign ci = active_flip[gi] ? (CW'(SPRITE_W - 1) - c) : c;
      assign slot_px[gi]  = active_row[gi][ci*BPP +: BPP];
      assign slot_hit[gi] = active_valid[gi] && (col11 >= lo) && (col11 < hi)
                            && (slot_px[gi] != '0);
    end
  endgenerate

  // Lowest slot wins; slots are filled in attribute-index order.
  logic [BPP-1:0] win_px;
  logic [3:0]     win_pal;
  logic           multi;
  logic           seen;

  always_comb begin
    win_px  = '0;
    win_pal = '0;
    multi   = 1'b0;
    seen    = 1'b0;
    for (int k = MAX_PER_LINE - 1; k >= 0; k--) begin
      if (slot_hit[k]) begin
        win_px  = slot_px[k];
        win_pal = active_pal[k];
        if (seen)
          multi = 1'b1;
        seen = 1'b1;
      end
    end
  end

  // ---------------- registered outputs ----------------
  logic visible;

  assign visible = (hcount < 11'd1280) && (vcount < 10'd480);

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_index     <= '0;
      pix_opaque    <= 1'b0;
      line_overflow <= 1'b0;
      collision     <= 1'b0;
    end else begin
      pix_index  <= (visible && seen) ? {win_pal, win_px} : '0;
      pix_opaque <= visible && seen;
      if (visible && multi)
        collision <= 1'b1;
      else if (hcount == 11'd0 && vcount == 10'd0)
        collision <= 1'b0;
      if (copy_active)
        line_overflow <= shadow_ovf;
    end
  end

endmodule

// File: tb/tb_sprite_line_engine.sv
// tb_sprite_line_engine
//   Directed bench for sprite_line_engine. The bench drives hcount/vcount
//   itself: a blanking interval is compressed to hcount=1280, a run of
//   non-trigger cycles, then hcount=1599, after which chosen columns of the
//   target line are probed one cycle each.
module tb_sprite_line_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic [15:0] address;
  logic [31:0] writedata;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [5:0]  pix_index;
  logic        pix_opaque;
  logic        line_overflow;
  logic        collision;

  int n_cmp  = 0;
  int n_fail = 0;

  sprite_line_engine dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .hcount       (hcount),
    .vcount       (vcount),
    .pix_index    (pix_index),
    .pix_opaque   (pix_opaque),
    .line_overflow(line_overflow),
    .collision    (collision)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      $display("check %s observed=%0h", tag, obs);
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] attr(input logic en, input logic flip, input logic [3:0] pal,
                                       input logic [6:0] pat, input logic [9:0] x,
                                       input logic [8:0] y);
    return {en, flip, pal, pat, x, y};
  endfunction

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write      = 1'b1;
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic set_pat(input int p, input logic [31:0] row);
    for (int r = 0; r < 16; r++)
      wr(16'h0100 | 16'(p * 16 + r), row);
  endtask

  // Run the blanking scan that prepares line l, then sit on line l.
  task automatic prep_line(input int l);
    vcount = (l == 0) ? 10'd524 : 10'(l - 1);
    hcount = 11'd1290;
    @(negedge clk);
    hcount = 11'd1280;
    @(negedge clk);
    hcount = 11'd1290;
    repeat (80) @(negedge clk);
    hcount = 11'd1599;
    @(negedge clk);
    vcount = 10'(l);
    hcount = 11'd1290;
  endtask

  // Probe one column; opaque is expected exactly when the index is nonzero.
  task automatic pix(input int col, input logic [5:0] exp_idx, input string tag);
    hcount = 11'(2 * col);
    @(negedge clk);
    check(tag, {25'd0, pix_opaque, pix_index}, {25'd0, exp_idx != 6'd0, exp_idx});
    hcount = 11'd1290;
  endtask

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    hcount     = 11'd1290;
    vcount     = 10'd0;
    repeat (3) @(negedge clk);
    check("rst_pix_index", 32'(pix_index), 32'd0);
    check("rst_pix_opaque", 32'(pix_opaque), 32'd0);
    check("rst_line_overflow", 32'(line_overflow), 32'd0);
    check("rst_collision", 32'(collision), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) wr(16'(i), 32'd0);

    // 1: single sprite, box edges
    set_pat(0, 32'h5555_5555);
    wr(16'h0000, attr(1'b1, 1'b0, 4'd3, 7'd0, 10'd100, 9'd50));
    prep_line(49);  pix(100, 6'h00, "t1_line49");
    prep_line(50);
    pix(99,  6'h00, "t1_col99");
    pix(100, 6'h0D, "t1_col100");
    pix(115, 6'h0D, "t1_col115");
    pix(116, 6'h00, "t1_col116");
    prep_line(65);  pix(107, 6'h0D, "t1_line65");
    prep_line(66);  pix(100, 6'h00, "t1_line66");

    // 2: overlap, priority, collision
    set_pat(0, 32'h0055_5555);
    set_pat(1, 32'hAAAA_AAAA);
    wr(16'h0001, attr(1'b1, 1'b0, 4'd5, 7'd1, 10'd108, 9'd50));
    prep_line(50);
    check("t2_coll_start", 32'(collision), 32'd0);
    pix(112, 6'h16, "t2_col112_attr1");
    check("t2_coll_no_overlap", 32'(collision), 32'd0);
    pix(108, 6'h0D, "t2_col108_attr0");
    check("t2_coll_set", 32'(collision), 32'd1);
    pix(111, 6'h0D, "t2_col111_attr0");
    pix(120, 6'h16, "t2_col120_attr1");
    prep_line(51);
    check("t2_coll_held", 32'(collision), 32'd1);
    vcount = 10'd0;
    hcount = 11'd0;
    @(negedge clk);
    check("t2_coll_cleared", 32'(collision), 32'd0);
    hcount = 11'd1290;

    // 3: more sprites than slots
    for (int i = 0; i < 10; i++)
      wr(16'(i), attr(1'b1, 1'b0, 4'(i), 7'd0, 10'(40 * i), 9'd200));
    prep_line(200);
    check("t3_ovf_l200", 32'(line_overflow), 32'd1);
    for (int i = 0; i < 10; i++)
      pix(40 * i + 2, (i < 8) ? 6'(i * 4 + 1) : 6'h00, $sformatf("t3_entry%0d", i));
    prep_line(215);
    check("t3_ovf_l215", 32'(line_overflow), 32'd1);
    pix(2, 6'h01, "t3_l215_entry0");
    prep_line(216);
    check("t3_ovf_l216", 32'(line_overflow), 32'd0);
    pix(2, 6'h00, "t3_l216_entry0");

    // 4: horizontal flip
    for (int i = 0; i < 10; i++) wr(16'(i), 32'd0);
    set_pat(2, 32'h0000_0003);
    wr(16'h0000, attr(1'b1, 1'b1, 4'd1, 7'd2, 10'd300, 9'd300));
    prep_line(300);
    pix(315, 6'h07, "t4_flip_col315");
    pix(300, 6'h00, "t4_flip_col300");
    pix(314, 6'h00, "t4_flip_col314");
    wr(16'h0000, attr(1'b1, 1'b0, 4'd1, 7'd2, 10'd300, 9'd300));
    prep_line(300);
    pix(300, 6'h07, "t4_noflip_col300");
    pix(315, 6'h00, "t4_noflip_col315");
    pix(301, 6'h00, "t4_noflip_col301");

    // 5: bottom clip, enable, top wrap
    wr(16'h0000, attr(1'b1, 1'b0, 4'd2, 7'd0, 10'd50, 9'd470));
    prep_line(470); pix(50, 6'h09, "t5_l470");
    prep_line(479); pix(50, 6'h09, "t5_l479");
                    pix(62, 6'h00, "t5_l479_transp");
    prep_line(480); pix(50, 6'h00, "t5_l480");
    wr(16'h0000, attr(1'b0, 1'b0, 4'd2, 7'd0, 10'd50, 9'd470));
    prep_line(470); pix(50, 6'h00, "t5_disabled");
    wr(16'h0000, attr(1'b1, 1'b0, 4'd2, 7'd0, 10'd50, 9'h1FC));
    prep_line(0);   pix(50, 6'h09, "t5_wrap_l0");
    prep_line(11);  pix(50, 6'h09, "t5_wrap_l11");
    prep_line(12);  pix(50, 6'h00, "t5_wrap_l12");

    // 6: reset in the middle of a scan
    wr(16'h0000, attr(1'b1, 1'b0, 4'd2, 7'd0, 10'd50, 9'd100));
    wr(16'h0001, attr(1'b1, 1'b0, 4'd5, 7'd1, 10'd50, 9'd100));
    prep_line(100);
    pix(50, 6'h09, "t6_before");
    check("t6_coll_before", 32'(collision), 32'd1);
    vcount = 10'd99;
    hcount = 11'd1280;
    @(negedge clk);
    hcount = 11'd1290;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_outputs_after_reset",
          {23'd0, collision, line_overflow, pix_opaque, pix_index}, 32'd0);
    repeat (80) @(negedge clk);
    hcount = 11'd1599;
    @(negedge clk);
    vcount = 10'd100;
    hcount = 11'd1290;
    pix(50, 6'h00, "t6_line_after_reset");
    prep_line(101);
    pix(50, 6'h09, "t6_following_line");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
